// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory, buffers returned words and hands {instr, pc} to decode.
module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC       = '0,
  parameter int unsigned            FIFO_DEPTH_POW = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                  imem_req_valid_out,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_out,
  input  logic                  imem_req_ready_in,
  input  logic                  imem_resp_valid_in,
  input  logic [31:0]           imem_resp_instr_in,
  output logic                  instr_valid_out,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc_out,
  input  logic                  instr_ready_in
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_POW;
  localparam int unsigned PW    = FIFO_DEPTH_POW;
  localparam int unsigned CW    = FIFO_DEPTH_POW + 1;
  localparam int unsigned CW1   = CW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

  state_t                state_q, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx;
  logic [ADDR_WIDTH-1:0] resp_pc, resp_pc_nx;
  logic [CW-1:0]         outstanding, outstanding_nx;
  logic [CW-1:0]         fifo_count, fifo_count_nx;
  logic [CW-1:0]         drop_cnt, drop_cnt_nx;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [31:0]           fifo_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];

  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  credit_ok, credits_nx;
  logic                  req_fire, resp_ok, resp_drop, push, pop;

  // Low address bits of a redirect are ignored; masking keeps every input bit in use.
  assign redirect_target = redirect_pc_in & ~ADDR_WIDTH'(3);

  // A request is allowed only if its word is guaranteed a FIFO slot on return.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < CW1'(DEPTH);

  assign imem_req_valid_out = ~reset & ~redirect_valid_in & credit_ok;
  assign imem_req_addr_out  = fetch_pc;

  assign instr_valid_out = ~reset & ~redirect_valid_in & (fifo_count != '0);
  assign instr_out       = instr_valid_out ? fifo_instr[rd_ptr] : '0;
  assign instr_pc_out    = instr_valid_out ? fifo_pc[rd_ptr]    : '0;

  assign req_fire  = imem_req_valid_out & imem_req_ready_in;
  assign resp_ok   = ~reset & imem_resp_valid_in & (outstanding != '0);
  assign resp_drop = resp_ok & ((drop_cnt != '0) | redirect_valid_in);
  assign push      = resp_ok & ~resp_drop;
  assign pop       = instr_valid_out & instr_ready_in;

  // Next-state, counters and PCs.
  always_comb begin
    state_nx       = state_q;
    fetch_pc_nx    = fetch_pc;
    resp_pc_nx     = resp_pc;
    outstanding_nx = outstanding + CW'(req_fire) - CW'(resp_ok);
    fifo_count_nx  = fifo_count + CW'(push) - CW'(pop);
    drop_cnt_nx    = drop_cnt - CW'(resp_ok && (drop_cnt != '0));

    if (redirect_valid_in) begin
      fetch_pc_nx   = redirect_target;
      resp_pc_nx    = redirect_target;
      fifo_count_nx = '0;
      drop_cnt_nx   = outstanding - CW'(resp_ok);
    end else begin
      if (req_fire) fetch_pc_nx = fetch_pc + ADDR_WIDTH'(4);
      if (push)     resp_pc_nx  = resp_pc + ADDR_WIDTH'(4);
    end

    credits_nx = ({1'b0, outstanding_nx} + {1'b0, fifo_count_nx}) < CW1'(DEPTH);

    unique case (state_q)
      ST_RUN:   if (!credits_nx) state_nx = ST_STALL;
      ST_STALL: if (credits_nx)  state_nx = ST_RUN;
      ST_FLUSH: if (drop_cnt_nx == '0) state_nx = credits_nx ? ST_RUN : ST_STALL;
      default:  state_nx = ST_RUN;
    endcase

    if (redirect_valid_in) state_nx = (drop_cnt_nx != '0) ? ST_FLUSH : ST_RUN;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      fifo_count  <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state_q     <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      resp_pc     <= resp_pc_nx;
      outstanding <= outstanding_nx;
      fifo_count  <= fifo_count_nx;
      drop_cnt    <= drop_cnt_nx;
      wr_ptr      <= redirect_valid_in ? '0 : wr_ptr + PW'(push);
      rd_ptr      <= redirect_valid_in ? '0 : rd_ptr + PW'(pop);
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_resp_instr_in;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_stall_no_req : assert property (@(posedge clk_in) disable iff (reset)
    (state_q == ST_STALL) |-> !imem_req_valid_out);
  a_flush_drop : assert property (@(posedge clk_in) disable iff (reset)
    (state_q == ST_FLUSH) == (drop_cnt != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming and
// redirect, then hand-written sequences for stalls, wrap and mid-stream reset.
module tb_fetch_unit;

  localparam int unsigned AW = 64;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          redirect_valid_in;
  logic [AW-1:0] redirect_pc_in;
  logic          imem_req_valid_out;
  logic [AW-1:0] imem_req_addr_out;
  logic          imem_req_ready_in;
  logic          imem_resp_valid_in;
  logic [31:0]   imem_resp_instr_in;
  logic          instr_valid_out;
  logic [31:0]   instr_out;
  logic [AW-1:0] instr_pc_out;
  logic          instr_ready_in;

  logic mem_auto;
  int   checks;
  int   errors;
  int   fires;

  always #5 clk_in = ~clk_in;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(64'h0), .FIFO_DEPTH_POW(1)) dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_addr_out  (imem_req_addr_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_resp_valid_in (imem_resp_valid_in),
    .imem_resp_instr_in (imem_resp_instr_in),
    .instr_valid_out    (instr_valid_out),
    .instr_out          (instr_out),
    .instr_pc_out       (instr_pc_out),
    .instr_ready_in     (instr_ready_in)
  );

  typedef struct {
    logic          rst;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          rsp_v;
    logic [31:0]   rsp_i;
    logic          dec_rdy;
    logic          e_rv;
    logic [AW-1:0] e_addr;
    logic          e_iv;
    logic [AW-1:0] e_pc;
    logic [31:0]   e_instr;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic rst, input logic redir, input logic [AW-1:0] rpc,
                              input logic rdy, input logic rsp_v, input logic [31:0] rsp_i,
                              input logic dec_rdy, input logic e_rv, input logic [AW-1:0] e_addr,
                              input logic e_iv, input logic [AW-1:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rsp_v = rsp_v;
    v.rsp_i = rsp_i; v.dec_rdy = dec_rdy; v.e_rv = e_rv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one cycle; with mem_auto set, a request accepted this cycle is answered next cycle.
  task automatic next_cycle();
    logic          fired;
    logic [AW-1:0] faddr;
    fired = mem_auto && imem_req_valid_out && imem_req_ready_in;
    faddr = imem_req_addr_out;
    @(posedge clk_in);
    @(negedge clk_in);
    imem_resp_valid_in = fired;
    imem_resp_instr_in = fired ? mem_word(faddr) : 32'h0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; redirect_valid_in = 1'b0; imem_resp_valid_in = 1'b0; mem_auto = 1'b0;
    next_cycle();
    reset = 1'b0; mem_auto = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; fires = 0; mem_auto = 1'b0;
    reset = 1'b1; redirect_valid_in = 1'b0; redirect_pc_in = '0; imem_req_ready_in = 1'b0;
    imem_resp_valid_in = 1'b0; imem_resp_instr_in = '0; instr_ready_in = 1'b0;

    //              rst redir rpc       rdy rv  rsp_i         dr  erv eaddr     eiv epc       einstr
    vecs[0]  = mk(1, 0, 64'h0,    0, 0, 32'h0,         0, 0, 64'h0,    0, 64'h0,    32'h0);
    vecs[1]  = mk(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h0,    0, 64'h0,    32'h0);
    vecs[2]  = mk(0, 0, 64'h0,    1, 1, 32'hA000_0000, 1, 1, 64'h4,    0, 64'h0,    32'h0);
    vecs[3]  = mk(0, 0, 64'h0,    1, 1, 32'hA000_0004, 1, 0, 64'h8,    1, 64'h0,    32'hA000_0000);
    vecs[4]  = mk(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h8,    1, 64'h4,    32'hA000_0004);
    vecs[5]  = mk(0, 0, 64'h0,    1, 1, 32'hA000_0008, 1, 1, 64'hC,    0, 64'h0,    32'h0);
    vecs[6]  = mk(0, 0, 64'h0,    1, 1, 32'hA000_000C, 1, 0, 64'h10,   1, 64'h8,    32'hA000_0008);
    vecs[7]  = mk(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h10,   1, 64'hC,    32'hA000_000C);
    vecs[8]  = mk(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h14,   0, 64'h0,    32'h0);
    vecs[9]  = mk(0, 1, 64'h1003, 1, 0, 32'h0,         1, 0, 64'h18,   0, 64'h0,    32'h0);
    vecs[10] = mk(0, 0, 64'h0,    1, 1, 32'hDEAD_0010, 1, 0, 64'h1000, 0, 64'h0,    32'h0);
    vecs[11] = mk(0, 0, 64'h0,    1, 1, 32'hDEAD_0014, 1, 1, 64'h1000, 0, 64'h0,    32'h0);
    vecs[12] = mk(0, 0, 64'h0,    1, 1, 32'hA000_1000, 1, 1, 64'h1004, 0, 64'h0,    32'h0);
    vecs[13] = mk(0, 0, 64'h0,    1, 1, 32'hA000_1004, 1, 0, 64'h1008, 1, 64'h1000, 32'hA000_1000);
    vecs[14] = mk(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h1008, 1, 64'h1004, 32'hA000_1004);
    vecs[15] = mk(0, 0, 64'h0,    1, 1, 32'hA000_1008, 1, 1, 64'h100C, 0, 64'h0,    32'h0);

    repeat (2) @(posedge clk_in);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      reset = vecs[i].rst; redirect_valid_in = vecs[i].redir; redirect_pc_in = vecs[i].rpc;
      imem_req_ready_in = vecs[i].rdy; imem_resp_valid_in = vecs[i].rsp_v;
      imem_resp_instr_in = vecs[i].rsp_i; instr_ready_in = vecs[i].dec_rdy;
      #2;
      chk($sformatf("v%0d_req_valid", i), AW'(imem_req_valid_out), AW'(vecs[i].e_rv));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr_out, vecs[i].e_addr);
      chk($sformatf("v%0d_instr_valid", i), AW'(instr_valid_out), AW'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_instr_pc", i), instr_pc_out, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), AW'(instr_out), AW'(vecs[i].e_instr));
      end
    end

    // Decoder stalled for 10 cycles: only two requests fit the two-entry buffer.
    reset_dut();
    instr_ready_in = 1'b0; imem_req_ready_in = 1'b1;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (imem_req_valid_out && imem_req_ready_in) fires++;
      next_cycle();
    end
    chk("stall_fire_count", AW'(fires), AW'(2));
    instr_ready_in = 1'b1;
    #2;
    chk("stall_req_low", AW'(imem_req_valid_out), AW'(0));
    chk("stall_first_pc", instr_pc_out, 64'h0);
    chk("stall_first_instr", AW'(instr_out), AW'(mem_word(64'h0)));
    next_cycle(); #2;
    chk("stall_req_resume", AW'(imem_req_valid_out), AW'(1));
    chk("stall_resume_addr", imem_req_addr_out, 64'h8);
    chk("stall_second_pc", instr_pc_out, 64'h4);
    next_cycle(); #2;
    chk("stall_no_bypass", AW'(instr_valid_out), AW'(0));
    next_cycle(); #2;
    chk("stall_third_valid", AW'(instr_valid_out), AW'(1));
    chk("stall_third_pc", instr_pc_out, 64'h8);

    // Memory not ready for 3 cycles at 0x20: address held, one fire.
    reset_dut();
    imem_req_ready_in = 1'b0; instr_ready_in = 1'b1;
    redirect_valid_in = 1'b1; redirect_pc_in = 64'h20;
    #2;
    chk("hold_redirect_no_req", AW'(imem_req_valid_out), AW'(0));
    next_cycle();
    redirect_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("hold_valid_%0d", i), AW'(imem_req_valid_out), AW'(1));
      chk($sformatf("hold_addr_%0d", i), imem_req_addr_out, 64'h20);
      next_cycle();
    end
    imem_req_ready_in = 1'b1;
    #2;
    chk("hold_fire_addr", imem_req_addr_out, 64'h20);
    next_cycle(); #2;
    chk("hold_next_addr", imem_req_addr_out, 64'h24);
    next_cycle(); #2;
    chk("hold_word_pc", instr_pc_out, 64'h20);
    chk("hold_word_instr", AW'(instr_out), AW'(mem_word(64'h20)));
    next_cycle(); #2;
    chk("hold_no_dup_pc", instr_pc_out, 64'h24);

    // Fetch PC wraps from 2^64-4 to 0.
    reset_dut();
    imem_req_ready_in = 1'b1; instr_ready_in = 1'b1;
    redirect_valid_in = 1'b1; redirect_pc_in = 64'hFFFF_FFFF_FFFF_FFFF;
    next_cycle();
    redirect_valid_in = 1'b0;
    #2;
    chk("wrap_addr_top", imem_req_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle(); #2;
    chk("wrap_addr_zero", imem_req_addr_out, 64'h0);
    next_cycle(); #2;
    chk("wrap_pc_top", instr_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr_top", AW'(instr_out), AW'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
    next_cycle(); #2;
    chk("wrap_pc_zero", instr_pc_out, 64'h0);

    // Fill the buffer, then reset mid-stream.
    next_cycle();
    instr_ready_in = 1'b0;
    repeat (3) next_cycle();
    #2;
    chk("full_valid", AW'(instr_valid_out), AW'(1));
    chk("full_req_low", AW'(imem_req_valid_out), AW'(0));
    reset = 1'b1; mem_auto = 1'b0; imem_resp_valid_in = 1'b0;
    #1;
    chk("rst_instr_valid", AW'(instr_valid_out), AW'(0));
    chk("rst_req_valid", AW'(imem_req_valid_out), AW'(0));
    next_cycle();
    reset = 1'b0; mem_auto = 1'b1;
    #2;
    chk("post_rst_instr_valid", AW'(instr_valid_out), AW'(0));
    chk("post_rst_req_valid", AW'(imem_req_valid_out), AW'(1));
    chk("post_rst_req_addr", imem_req_addr_out, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
